// File: rtl/coin_pkg.sv
// Shared encodings for the change dispenser: FSM states, dispense commands
// and the value of each command in nickel units.
package coin_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DRIVE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_NICKEL,
    CMD_DIME,
    CMD_TWO_DIME
  } cmd_t;

  localparam int NICKEL_U   = 1;
  localparam int DIME_U     = 2;
  localparam int TWO_DIME_U = 4;

endpackage

// File: rtl/change_planner.sv
// Greedy coin selector: picks the largest allowed command that fits in the
// remaining amount and returns the amount left after issuing it.
module change_planner
  import coin_pkg::*;
#(
  parameter int AMT_W        = 8,
  parameter bit USE_TWO_DIME = 1'b1
) (
  input  logic [AMT_W-1:0] remaining,
  output cmd_t             cmd,
  output logic [AMT_W-1:0] next_remaining
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed path would infer a latch.
    cmd            = CMD_NONE;
    next_remaining = remaining;
    if (USE_TWO_DIME && remaining >= AMT_W'(TWO_DIME_U)) begin
      cmd            = CMD_TWO_DIME;
      next_remaining = remaining - AMT_W'(TWO_DIME_U);
    end else if (remaining >= AMT_W'(DIME_U)) begin
      cmd            = CMD_DIME;
      next_remaining = remaining - AMT_W'(DIME_U);
    end else if (remaining != '0) begin
      cmd            = CMD_NICKEL;
      next_remaining = remaining - AMT_W'(NICKEL_U);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Sequencer in front of coin_counter: turns restocks into a one-cycle load and
// change requests into greedy one-hot dispense commands, one per two cycles.
module change_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W        = 8,
  parameter int CNT_W        = 8,
  parameter bit USE_TWO_DIME = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             restock_valid,
  input  logic [CNT_W-1:0] restock_nickels,
  input  logic [CNT_W-1:0] restock_dimes,
  output logic             restock_ready,
  output logic             done,
  output logic             done_ok,
  output logic [AMT_W-1:0] done_remaining,
  output logic             busy,
  input  logic             empty,
  output logic             load,
  output logic [CNT_W-1:0] nickels,
  output logic [CNT_W-1:0] dimes,
  output logic             nickel_out,
  output logic             dime_out,
  output logic             two_dime_out
);

  state_t           state;
  logic [AMT_W-1:0] remaining;
  cmd_t             plan_cmd;
  logic [AMT_W-1:0] plan_next;

  change_planner #(
    .AMT_W       (AMT_W),
    .USE_TWO_DIME(USE_TWO_DIME)
  ) u_planner (
    .remaining     (remaining),
    .cmd           (plan_cmd),
    .next_remaining(plan_next)
  );

  // Handshake outputs may look at inputs; the coin_counter side is flops only.
  assign busy          = (state != S_IDLE);
  assign restock_ready = (state == S_IDLE);
  assign req_ready     = (state == S_IDLE) && !restock_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      remaining      <= '0;
      load           <= 1'b0;
      nickels        <= '0;
      dimes          <= '0;
      nickel_out     <= 1'b0;
      dime_out       <= 1'b0;
      two_dime_out   <= 1'b0;
      done           <= 1'b0;
      done_ok        <= 1'b0;
      done_remaining <= '0;
    end else begin
      // NOTE: non-blocking throughout so every flop samples pre-edge values.
      load         <= 1'b0;
      nickel_out   <= 1'b0;
      dime_out     <= 1'b0;
      two_dime_out <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (restock_valid) begin
            nickels <= restock_nickels;
            dimes   <= restock_dimes;
            load    <= 1'b1;
            state   <= S_LOAD;
          end else if (req_valid) begin
            remaining <= req_amount;
            state     <= S_CHECK;
          end
        end
        S_LOAD:  state <= S_IDLE;
        S_CHECK: begin
          // Zero remaining wins over empty: a fully paid request is a success.
          if (remaining == '0) begin
            done           <= 1'b1;
            done_ok        <= 1'b1;
            done_remaining <= '0;
            state          <= S_DONE;
          end else if (empty) begin
            done           <= 1'b1;
            done_ok        <= 1'b0;
            done_remaining <= remaining;
            state          <= S_DONE;
          end else begin
            nickel_out   <= (plan_cmd == CMD_NICKEL);
            dime_out     <= (plan_cmd == CMD_DIME);
            two_dime_out <= (plan_cmd == CMD_TWO_DIME);
            remaining    <= plan_next;
            state        <= S_DRIVE;
          end
        end
        S_DRIVE: state <= S_CHECK;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Drives two dispensers (with and without the two-dime command) with the same
// requests and checks each against a coin-list model and an emulated coin store.
module tb_change_dispenser;

  localparam int AMT_W = 8;
  localparam int CNT_W = 8;
  localparam int NEVER = 1000;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             restock_valid;
  logic [CNT_W-1:0] restock_nickels, restock_dimes;

  logic             req_ready_a, restock_ready_a, done_a, done_ok_a, busy_a, empty_a;
  logic             load_a, nick_a, dime_a, two_a;
  logic [AMT_W-1:0] done_rem_a;
  logic [CNT_W-1:0] nickels_a, dimes_a;

  logic             req_ready_b, restock_ready_b, done_b, done_ok_b, busy_b, empty_b;
  logic             load_b, nick_b, dime_b, two_b;
  logic [AMT_W-1:0] done_rem_b;
  logic [CNT_W-1:0] nickels_b, dimes_b;

  int checks = 0;
  int errors = 0;
  int used_a, used_b, lim_a, lim_b;

  always #5 clk = ~clk;

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .USE_TWO_DIME(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready_a),
    .restock_valid(restock_valid), .restock_nickels(restock_nickels),
    .restock_dimes(restock_dimes), .restock_ready(restock_ready_a),
    .done(done_a), .done_ok(done_ok_a), .done_remaining(done_rem_a), .busy(busy_a),
    .empty(empty_a), .load(load_a), .nickels(nickels_a), .dimes(dimes_a),
    .nickel_out(nick_a), .dime_out(dime_a), .two_dime_out(two_a)
  );

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .USE_TWO_DIME(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready_b),
    .restock_valid(restock_valid), .restock_nickels(restock_nickels),
    .restock_dimes(restock_dimes), .restock_ready(restock_ready_b),
    .done(done_b), .done_ok(done_ok_b), .done_remaining(done_rem_b), .busy(busy_b),
    .empty(empty_b), .load(load_b), .nickels(nickels_b), .dimes(dimes_b),
    .nickel_out(nick_b), .dime_out(dime_b), .two_dime_out(two_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected behaviour from the coin list: greedy change is (amount/4) two-dimes
  // (if allowed), then dimes, then at most one nickel; the store allows lim commands.
  task automatic compare_model(input string tag, input int amount, input bit two, input int lim,
                               input int cq[$], input int oq[$], input int doff, input int nd,
                               input logic ok, input logic [AMT_W-1:0] rem);
    int coins[$];
    int r, issued, owed;
    r = amount;
    if (two) begin
      repeat (amount / 4) coins.push_back(4);
      r = amount % 4;
    end
    repeat (r / 2) coins.push_back(2);
    if (r % 2 == 1) coins.push_back(1);
    issued = (coins.size() < lim) ? coins.size() : lim;
    owed   = amount;
    for (int i = 0; i < issued; i++) owed -= coins[i];
    check({tag, "/ncmd"}, cq.size(), issued);
    for (int i = 0; i < cq.size() && i < issued; i++) begin
      check($sformatf("%s/cmd%0d", tag, i), cq[i], coins[i]);
      check($sformatf("%s/cmd%0d_time", tag, i), oq[i], 2 * i + 1);
    end
    check({tag, "/done_time"}, doff, 2 * issued + 1);
    check({tag, "/done_count"}, nd, 1);
    check({tag, "/done_ok"}, ok, (owed == 0));
    check({tag, "/done_rem"}, rem, owed);
  endtask

  // Offsets count clock edges after the accepting edge: command i shows after
  // edge 2i+1, done after edge 2k+1. The store goes empty once lim commands end.
  task automatic run_txn(input string tag, input int amount, input int la, input int lb);
    int  c, da, db, nda, ndb;
    int  ca[$], oa[$], cb[$], ob[$];
    logic oka, okb;
    logic [AMT_W-1:0] ra, rb;
    bit  cmd;
    used_a = 0; used_b = 0; lim_a = la; lim_b = lb;
    empty_a = (lim_a <= 0); empty_b = (lim_b <= 0);
    da = -1; db = -1; nda = 0; ndb = 0; oka = 1'bx; okb = 1'bx; ra = 'x; rb = 'x;
    req_amount = AMT_W'(amount);
    req_valid  = 1'b1;
    check({tag, "/req_ready"}, {req_ready_a, req_ready_b}, 2'b11);
    @(posedge clk); #1;
    req_valid = 1'b0;
    c = 0;
    while (!(nda > 0 && ndb > 0) && c < 200) begin
      check({tag, "/onehot_a"}, ($countones({load_a, nick_a, dime_a, two_a}) <= 1), 1);
      check({tag, "/onehot_b"}, ($countones({load_b, nick_b, dime_b, two_b}) <= 1), 1);
      cmd = nick_a | dime_a | two_a;
      if (cmd) begin
        ca.push_back(two_a ? 4 : dime_a ? 2 : 1);
        oa.push_back(c);
      end
      if (done_a) begin
        nda++;
        if (nda == 1) begin da = c; oka = done_ok_a; ra = done_rem_a; end
      end
      empty_a = (used_a >= lim_a);
      if (cmd) used_a++;
      cmd = nick_b | dime_b | two_b;
      if (cmd) begin
        cb.push_back(two_b ? 4 : dime_b ? 2 : 1);
        ob.push_back(c);
      end
      if (done_b) begin
        ndb++;
        if (ndb == 1) begin db = c; okb = done_ok_b; rb = done_rem_b; end
      end
      empty_b = (used_b >= lim_b);
      if (cmd) used_b++;
      @(posedge clk); #1;
      c++;
    end
    check({tag, "/finished"}, (nda > 0 && ndb > 0), 1);
    // The DUT that finished first must stay quiet while the other one works.
    check({tag, "/a_idle_after"}, {busy_a, done_a}, 2'b00);
    check({tag, "/b_idle_after"}, {busy_b, done_b}, 2'b00);
    compare_model({tag, "/a"}, amount, 1'b1, la, ca, oa, da, nda, oka, ra);
    compare_model({tag, "/b"}, amount, 1'b0, lb, cb, ob, db, ndb, okb, rb);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "/coin_a"}, {load_a, nick_a, dime_a, two_a, nickels_a, dimes_a}, '0);
    check({tag, "/coin_b"}, {load_b, nick_b, dime_b, two_b, nickels_b, dimes_b}, '0);
    check({tag, "/status_a"}, {done_a, done_ok_a, done_rem_a, busy_a}, '0);
    check({tag, "/status_b"}, {done_b, done_ok_b, done_rem_b, busy_b}, '0);
  endtask

  initial begin
    int amt, la, lb, nd;
    reset_n = 1'b0; req_valid = 1'b0; req_amount = '0; restock_valid = 1'b0;
    restock_nickels = '0; restock_dimes = '0; empty_a = 1'b0; empty_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_held");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check_quiet("reset");
    check("reset/ready", {req_ready_a, restock_ready_a, req_ready_b, restock_ready_b}, 4'hf);

    // Restock and request together: restock wins, request follows after LOAD.
    restock_valid = 1'b1; restock_nickels = 8'd10; restock_dimes = 8'd5;
    req_valid = 1'b1; req_amount = 8'd3;
    #1;
    check("prio/req_ready", {req_ready_a, req_ready_b}, 2'b00);
    check("prio/restock_ready", {restock_ready_a, restock_ready_b}, 2'b11);
    @(posedge clk); #1;
    restock_valid = 1'b0;
    check("prio/load", {load_a, load_b}, 2'b11);
    check("prio/counts_a", {nickels_a, dimes_a}, {8'd10, 8'd5});
    check("prio/counts_b", {nickels_b, dimes_b}, {8'd10, 8'd5});
    check("prio/req_ready_in_load", {req_ready_a, req_ready_b}, 2'b00);
    @(posedge clk); #1;
    check("prio/load_drop", {load_a, load_b}, 2'b00);
    run_txn("prio_req", 3, NEVER, NEVER);

    run_txn("amt7", 7, NEVER, NEVER);
    run_txn("amt7_dry", 7, 1, 1);
    run_txn("amt0", 0, NEVER, NEVER);
    run_txn("amt0_dry", 0, 0, 0);
    run_txn("amt5", 5, NEVER, NEVER);
    run_txn("dry_at_start", 6, 0, 0);
    run_txn("dry_on_last", 6, 2, 3);

    for (int i = 0; i < 24; i++) begin
      amt = $urandom_range(0, 60);
      la  = ($urandom_range(0, 2) == 0) ? NEVER : $urandom_range(0, 10);
      lb  = ($urandom_range(0, 2) == 0) ? NEVER : $urandom_range(0, 10);
      run_txn($sformatf("rand%0d", i), amt, la, lb);
    end

    // Reset during DRIVE: command drops at once, no done pulse follows.
    used_a = 0; used_b = 0; lim_a = NEVER; lim_b = NEVER; empty_a = 1'b0; empty_b = 1'b0;
    req_amount = 8'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_reset/first_cmd", {two_a, dime_b}, 2'b11);
    reset_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    @(negedge clk) reset_n = 1'b1;
    nd = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_a || done_b) nd++;
    end
    check("mid_reset/no_done", nd, 0);
    check("mid_reset/idle", {busy_a, busy_b}, 2'b00);
    check("mid_reset/req_ready", {req_ready_a, req_ready_b}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
